// File: rtl/i2s_dac_serializer_if.sv
// i2s_dac_serializer_if: stereo sample stream into the DAC serializer
// audioIn  : stereo word {left, right}, 2*SAMPLE_W bits
// in_valid : producer holds a new sample
// in_ready : serializer buffer can take a sample this cycle (transfer = valid & ready)
interface i2s_dac_serializer_if #(
    parameter int SAMPLE_W = 16
);
    logic [2*SAMPLE_W-1:0] audioIn;
    logic                  in_valid;
    logic                  in_ready;
    modport master (output audioIn, in_valid, input in_ready);
    modport slave  (input audioIn, in_valid, output in_ready);
endinterface

// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: buffers a stereo word and shifts it MSB-first onto the codec DAC line
// clk          : system clock (>= 8x AUD_BCLK)
// rst          : asynchronous active-low reset
// AUD_BCLK     : codec bit clock, oversampled as data
// AUD_DACLRCK  : codec frame clock, high = left, low = right
// s_in         : sample stream (audioIn / in_valid / in_ready)
// AUD_DACDAT   : serial data to the codec
// frame_start  : one-clk pulse when a frame enters the shifter
// underrun     : sticky, set when a frame starts with the buffer empty
// underrun_clr : clears underrun (a simultaneous new underrun wins)
module i2s_dac_serializer #(
    parameter int SAMPLE_W    = 16,
    parameter int I2S_DELAY   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       AUD_BCLK,
    input  logic                       AUD_DACLRCK,
    i2s_dac_serializer_if.slave        s_in,
    output logic                       AUD_DACDAT,
    output logic                       frame_start,
    output logic                       underrun,
    input  logic                       underrun_clr
);
    localparam int FW = 2 * SAMPLE_W;
    localparam int CW = $clog2(SAMPLE_W + I2S_DELAY + 1);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
    logic                   bclk_prev, lr_q, primed, ready_en, full;
    logic [FW-1:0]          buffer, frame;
    logic [SAMPLE_W-1:0]    ch, ch_n, half;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   dat_n, bclk_fall, boundary, left_start, wr;

    // primed masks the first falling edge after reset so a mid-frame LRCK level is never taken as a boundary
    assign bclk_fall      = bclk_prev & ~bclk_sync[SYNC_STAGES-1];
    assign boundary       = bclk_fall & primed & (lrck_sync[SYNC_STAGES-1] != lr_q);
    assign left_start     = boundary & lrck_sync[SYNC_STAGES-1];
    assign frame_start    = left_start;
    assign s_in.in_ready  = ready_en & (~full | left_start);
    assign wr             = s_in.in_valid & s_in.in_ready;
    // on a left start the shifter takes the buffer if full, otherwise the previous frame repeats
    assign half = left_start ? (full ? buffer[FW-1:SAMPLE_W] : frame[FW-1:SAMPLE_W])
                             : frame[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_prev <= 1'b0;
            lr_q      <= 1'b0;
            primed    <= 1'b0;
            ready_en  <= 1'b0;
            full      <= 1'b0;
            buffer    <= '0;
            frame     <= '0;
            underrun  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            ready_en  <= 1'b1;
            if (bclk_fall) begin
                lr_q   <= lrck_sync[SYNC_STAGES-1];
                primed <= 1'b1;
            end
            if (wr)
                buffer <= s_in.audioIn;
            full     <= wr | (full & ~left_start);
            if (left_start & full)
                frame <= buffer;
            underrun <= (left_start & ~full) | (underrun & ~underrun_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ch         <= '0;
            AUD_DACDAT <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ch         <= ch_n;
            AUD_DACDAT <= dat_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch_n    = ch;
        dat_n   = AUD_DACDAT;
        if (boundary && (state != IDLE || left_start)) begin
            if (I2S_DELAY == 0) begin
                state_n = SHIFT;
                cnt_n   = CW'(1);
                dat_n   = half[SAMPLE_W-1];
                ch_n    = half << 1;
            end else begin
                state_n = DELAY;
                cnt_n   = CW'(I2S_DELAY);
                dat_n   = 1'b0;
                ch_n    = half;
            end
        end else if (bclk_fall) begin
            case (state)
                DELAY: begin
                    if (cnt == CW'(1)) begin
                        state_n = SHIFT;
                        dat_n   = ch[SAMPLE_W-1];
                        ch_n    = ch << 1;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(SAMPLE_W)) begin
                        state_n = PAD;
                        dat_n   = 1'b0;
                    end else begin
                        dat_n = ch[SAMPLE_W-1];
                        ch_n  = ch << 1;
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: dat_n = 1'b0;
            endcase
        end
    end
endmodule

// File: doc/i2s_dac_serializer.md
Name: i2s_dac_serializer

Overview:
- Downstream stage of the audio filter chain: takes the filtered 32-bit stereo word (left in [31:16], right in [15:0]) and serializes it onto the codec DAC data line.
- Runs on the system clock. Oversamples the codec bit clock (AUD_BCLK) and DAC frame clock (AUD_DACLRCK).
- One-deep sample buffer with a valid/ready handshake; underrun detection; left-justified or I2S bit alignment.

Parameters:
- SAMPLE_W, 16, bits per channel; the frame word is 2*SAMPLE_W.
- I2S_DELAY, 0, BCLK slots between a frame-clock edge and the channel MSB (0 = left-justified, 1 = I2S).
- SYNC_STAGES, 2, flip-flops in the synchronizers on AUD_BCLK and AUD_DACLRCK (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the AUD_BCLK frequency.
- rst  in  1  asynchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock; sampled as data, never used as a clock.
- AUD_DACLRCK  in  1  codec DAC frame clock; high = left channel, low = right channel.
- audioIn  in  2*SAMPLE_W  stereo sample {left, right}.
- in_valid  in  1  audioIn holds a new sample.
- in_ready  out  1  buffer can accept a sample this cycle.
- AUD_DACDAT  out  1  serial data to the codec, MSB first.
- frame_start  out  1  one-clk pulse when a stereo frame is loaded into the shifter.
- underrun  out  1  sticky; set when a frame starts with the buffer empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous, active-low on rst.
- Reset values:
  - AUD_DACDAT=0, in_ready=0, frame_start=0, underrun=0.
  - Buffer empty, shifter=0, bit counter=0, state=IDLE.
  - Synchronizer flops = 0.
  - in_ready goes to 1 on the first clk after reset is released.
- Synchronization:
  - AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flops.
  - bclk_fall = previous synced BCLK 1 and current synced BCLK 0.
- Per bclk_fall:
  - Capture the synced LRCK into lr_q.
  - A boundary is lr_q != its previous value.
  - Rising boundary = left start; falling boundary = right start.
- Buffer:
  - Handshake transfer = in_valid & in_ready; it writes audioIn into the buffer and marks it full.
  - in_ready = !full | load_now, where load_now is a left-start boundary that consumes the buffer in the same cycle.
  - A simultaneous write and load is legal: the shifter takes the old buffer contents, and the buffer takes the new sample and stays full.
- Frame load (left-start boundary):
  - Buffer full: shifter <= buffer, buffer marked empty.
  - Buffer empty: shifter reloads the previous frame (repeat) and underrun <= 1.
  - In both cases frame_start pulses for one clk.
  - If underrun_clr and a new underrun occur in the same clk, set wins.
- State machine. States: IDLE, DELAY, SHIFT, PAD.
  - IDLE: AUD_DACDAT=0. Wait for the first left-start boundary; no output is ever driven mid-frame after reset.
  - Any boundary -> DELAY with count=I2S_DELAY, selecting the left or right half.
  - If I2S_DELAY=0, go straight to SHIFT and drive the MSB in the same clk as the boundary.
  - DELAY: on each bclk_fall decrement count. At 0 enter SHIFT and drive the MSB.
  - SHIFT: on each bclk_fall drive the next bit. After SAMPLE_W bits -> PAD.
  - PAD: AUD_DACDAT=0 until the next boundary.
  - A boundary arriving while in SHIFT or DELAY (short frame) aborts the current channel and restarts per the boundary rule.
  - Right-start boundaries never load the buffer; they shift the right half of the already-loaded frame.
- Latency:
  - AUD_DACDAT changes SYNC_STAGES+1 clks after the physical BCLK falling edge.
  - This stays well inside the half BCLK period under the 8x clock ratio.
- Reset mid-frame: outputs return to reset values at once; the block restarts from IDLE.

Test Plan:
- Reset, then accept 0xA5A5_3C3C. Run BCLK = clk/16 with 32-BCLK half-frames, I2S_DELAY=0 -> left slots 0..15 = 1010010110100101, right slots = 0011110000111100, remaining slots 0.
- Same stimulus with I2S_DELAY=1 -> the first slot after each LRCK edge is 0 and the data is shifted one slot later.
- No sample presented before the second frame -> frame_start pulses, the frame repeats 0xA5A5_3C3C, underrun=1. Pulse underrun_clr -> underrun=0.
- in_valid held high continuously -> in_ready=0 while full. A new sample is accepted in the exact clk of frame_start; no sample is lost or duplicated across 4 frames (0x0001_0002, 0x0003_0004, ...).
- Assert rst low mid-left-channel -> AUD_DACDAT=0 immediately. After release there is no output until the next rising LRCK boundary.
- Short frame with LRCK toggling after 8 BCLKs -> the current channel is aborted and the right channel MSB is driven on that boundary.
